// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite arbiter: FSM state encoding,
// response codes and the grant-index width helper.
package axil_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // A single master still needs a 1-bit index so ports never collapse to zero width.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: round-robin search starting at ptr with wrap,
// or fixed priority (lowest index) when RR_EN is 0.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1,
    parameter bit RR_EN = 1'b1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win,
    output logic             any
);

    int   base_c;
    int   idx_c;
    logic found_c;

    always_comb begin
        win     = '0;
        found_c = 1'b0;
        idx_c   = 0;
        base_c  = RR_EN ? int'(ptr) : 0;
        for (int k = 0; k < N; k++) begin
            idx_c = (base_c + k) % N;
            if (!found_c && req[idx_c]) begin
                win     = IDX_W'(idx_c);
                found_c = 1'b1;
            end
        end
        any = found_c;
    end

endmodule

// File: rtl/axil_rr_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter. One read or write transaction owns the
// slave at a time; grants are fixed priority or round-robin.
module axil_rr_arbiter
    import axil_pkg::*;
#(
    parameter int  NUM_M  = 2,
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 32,
    parameter bit  RR_EN  = 1'b1,
    localparam int IDX_W  = idx_w(NUM_M),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_M*ADDR_W-1:0]  m_araddr,
    input  logic [NUM_M-1:0]         m_arvalid,
    output logic [NUM_M-1:0]         m_arready,
    output logic [NUM_M*DATA_W-1:0]  m_rdata,
    output logic [NUM_M*2-1:0]       m_rresp,
    output logic [NUM_M-1:0]         m_rvalid,
    input  logic [NUM_M-1:0]         m_rready,
    input  logic [NUM_M*ADDR_W-1:0]  m_awaddr,
    input  logic [NUM_M-1:0]         m_awvalid,
    output logic [NUM_M-1:0]         m_awready,
    input  logic [NUM_M*DATA_W-1:0]  m_wdata,
    input  logic [NUM_M*STRB_W-1:0]  m_wstrb,
    input  logic [NUM_M-1:0]         m_wvalid,
    output logic [NUM_M-1:0]         m_wready,
    output logic [NUM_M*2-1:0]       m_bresp,
    output logic [NUM_M-1:0]         m_bvalid,
    input  logic [NUM_M-1:0]         m_bready,
    output logic [ADDR_W-1:0]        s_araddr,
    output logic                     s_arvalid,
    input  logic                     s_arready,
    input  logic [DATA_W-1:0]        s_rdata,
    input  logic [1:0]               s_rresp,
    input  logic                     s_rvalid,
    output logic                     s_rready,
    output logic [ADDR_W-1:0]        s_awaddr,
    output logic                     s_awvalid,
    input  logic                     s_awready,
    output logic [DATA_W-1:0]        s_wdata,
    output logic [STRB_W-1:0]        s_wstrb,
    output logic                     s_wvalid,
    input  logic                     s_wready,
    input  logic [1:0]               s_bresp,
    input  logic                     s_bvalid,
    output logic                     s_bready,
    output logic                     busy,
    output logic [IDX_W-1:0]         grant_id
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             is_write_q, is_write_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;

    logic [NUM_M-1:0] req;
    logic [IDX_W-1:0] pick_win;
    logic             pick_any;
    logic             aw_hs, w_hs, txn_end;

    assign req = m_arvalid | m_awvalid | m_wvalid;

    rr_picker #(
        .N     (NUM_M),
        .IDX_W (IDX_W),
        .RR_EN (RR_EN)
    ) u_picker (
        .req (req),
        .ptr (rr_ptr_q),
        .win (pick_win),
        .any (pick_any)
    );

    // Payload buses follow the current owner; responses are broadcast and
    // qualified per master by the valid bits alone.
    assign s_araddr = m_araddr[int'(grant_q)*ADDR_W +: ADDR_W];
    assign s_awaddr = m_awaddr[int'(grant_q)*ADDR_W +: ADDR_W];
    assign s_wdata  = m_wdata[int'(grant_q)*DATA_W +: DATA_W];
    assign s_wstrb  = m_wstrb[int'(grant_q)*STRB_W +: STRB_W];
    assign m_rdata  = {NUM_M{s_rdata}};
    assign m_rresp  = {NUM_M{s_rresp}};
    assign m_bresp  = {NUM_M{s_bresp}};

    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        is_write_d = is_write_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        aw_hs      = 1'b0;
        w_hs       = 1'b0;
        txn_end    = 1'b0;
        m_arready  = '0;
        m_rvalid   = '0;
        m_awready  = '0;
        m_wready   = '0;
        m_bvalid   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_win;
                    is_write_d = ~m_arvalid[pick_win];
                    state_d    = m_arvalid[pick_win] ? RD_A : WR_AW;
                end
            end
            RD_A: begin
                s_arvalid          = m_arvalid[grant_q];
                m_arready[grant_q] = s_arready;
                if (s_arvalid && s_arready) state_d = RD_D;
            end
            RD_D: begin
                s_rready          = m_rready[grant_q];
                m_rvalid[grant_q] = s_rvalid;
                txn_end           = s_rvalid & s_rready;
            end
            WR_AW: begin
                // A completed channel is fenced off so it cannot handshake twice.
                s_awvalid          = m_awvalid[grant_q] & ~aw_done_q;
                m_awready[grant_q] = s_awready & ~aw_done_q;
                s_wvalid           = m_wvalid[grant_q] & ~w_done_q;
                m_wready[grant_q]  = s_wready & ~w_done_q;
                aw_hs              = s_awvalid & s_awready;
                w_hs               = s_wvalid & s_wready;
                aw_done_d          = aw_done_q | aw_hs;
                w_done_d           = w_done_q | w_hs;
                if (aw_done_d && w_done_d) state_d = WR_B;
            end
            WR_B: begin
                if (is_write_q) begin
                    s_bready          = m_bready[grant_q];
                    m_bvalid[grant_q] = s_bvalid;
                end
                txn_end = s_bvalid & s_bready;
            end
            default: state_d = IDLE;
        endcase

        if (txn_end) begin
            state_d   = IDLE;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (RR_EN) begin
                rr_ptr_d = (grant_q == IDX_W'(NUM_M - 1)) ? '0 : grant_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            is_write_q <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            is_write_q <= is_write_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Directed bench: a 3-master round-robin arbiter and a 2-master fixed-priority
// arbiter, each in front of a small behavioural slave.
module tb_axil_rr_arbiter;
    import axil_pkg::*;

    localparam int AN = 3;
    localparam int BN = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // ---------------- DUT A: 3 masters, round-robin ----------------
    logic [AN*32-1:0] a_m_araddr, a_m_rdata, a_m_awaddr, a_m_wdata;
    logic [AN-1:0]    a_m_arvalid, a_m_arready, a_m_rvalid, a_m_rready;
    logic [AN-1:0]    a_m_awvalid, a_m_awready, a_m_wvalid, a_m_wready;
    logic [AN-1:0]    a_m_bvalid, a_m_bready;
    logic [AN*2-1:0]  a_m_rresp, a_m_bresp;
    logic [AN*4-1:0]  a_m_wstrb;
    logic [31:0]      a_s_araddr, a_s_rdata, a_s_awaddr, a_s_wdata;
    logic [3:0]       a_s_wstrb;
    logic [1:0]       a_s_rresp, a_s_bresp;
    logic             a_s_arvalid, a_s_arready, a_s_rvalid, a_s_rready;
    logic             a_s_awvalid, a_s_awready, a_s_wvalid, a_s_wready;
    logic             a_s_bvalid, a_s_bready;
    logic             a_busy;
    logic [1:0]       a_grant;
    logic [19:0]      a_ctl;

    axil_rr_arbiter #(.NUM_M(AN), .ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .m_araddr(a_m_araddr), .m_arvalid(a_m_arvalid), .m_arready(a_m_arready),
        .m_rdata(a_m_rdata), .m_rresp(a_m_rresp), .m_rvalid(a_m_rvalid), .m_rready(a_m_rready),
        .m_awaddr(a_m_awaddr), .m_awvalid(a_m_awvalid), .m_awready(a_m_awready),
        .m_wdata(a_m_wdata), .m_wstrb(a_m_wstrb), .m_wvalid(a_m_wvalid), .m_wready(a_m_wready),
        .m_bresp(a_m_bresp), .m_bvalid(a_m_bvalid), .m_bready(a_m_bready),
        .s_araddr(a_s_araddr), .s_arvalid(a_s_arvalid), .s_arready(a_s_arready),
        .s_rdata(a_s_rdata), .s_rresp(a_s_rresp), .s_rvalid(a_s_rvalid), .s_rready(a_s_rready),
        .s_awaddr(a_s_awaddr), .s_awvalid(a_s_awvalid), .s_awready(a_s_awready),
        .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb), .s_wvalid(a_s_wvalid), .s_wready(a_s_wready),
        .s_bresp(a_s_bresp), .s_bvalid(a_s_bvalid), .s_bready(a_s_bready),
        .busy(a_busy), .grant_id(a_grant)
    );

    assign a_ctl = {a_m_arready, a_m_rvalid, a_m_awready, a_m_wready, a_m_bvalid,
                    a_s_arvalid, a_s_rready, a_s_awvalid, a_s_wvalid, a_s_bready};

    // Slave A: always-ready address/data, read data after a programmable delay.
    logic [3:0]  a_rd_lat, a_rd_cnt;
    logic [31:0] a_rd_data;
    logic        a_rd_pend, a_aw_seen, a_w_seen;
    logic [7:0]  a_aw_cnt, a_w_cnt;
    logic [31:0] a_cap_wdata, a_cap_awaddr;
    logic [3:0]  a_cap_wstrb;

    assign a_s_arready = 1'b1;
    assign a_s_awready = 1'b1;
    assign a_s_wready  = 1'b1;
    assign a_s_rdata   = a_rd_data;
    assign a_s_rresp   = RESP_OKAY;
    assign a_s_bresp   = RESP_OKAY;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rd_pend  <= 1'b0;
            a_rd_cnt   <= '0;
            a_s_rvalid <= 1'b0;
            a_aw_seen  <= 1'b0;
            a_w_seen   <= 1'b0;
            a_s_bvalid <= 1'b0;
            a_aw_cnt   <= '0;
            a_w_cnt    <= '0;
        end else begin
            if (a_s_arvalid && a_s_arready) begin
                a_rd_pend <= 1'b1;
                a_rd_cnt  <= a_rd_lat;
            end else if (a_rd_pend) begin
                if (a_rd_cnt == 0) begin
                    a_rd_pend  <= 1'b0;
                    a_s_rvalid <= 1'b1;
                end else begin
                    a_rd_cnt <= a_rd_cnt - 1'b1;
                end
            end
            if (a_s_rvalid && a_s_rready) a_s_rvalid <= 1'b0;
            if (a_s_awvalid && a_s_awready) begin
                a_aw_seen    <= 1'b1;
                a_aw_cnt     <= a_aw_cnt + 1'b1;
                a_cap_awaddr <= a_s_awaddr;
            end
            if (a_s_wvalid && a_s_wready) begin
                a_w_seen    <= 1'b1;
                a_w_cnt     <= a_w_cnt + 1'b1;
                a_cap_wdata <= a_s_wdata;
                a_cap_wstrb <= a_s_wstrb;
            end
            if ((a_aw_seen || (a_s_awvalid && a_s_awready)) &&
                (a_w_seen || (a_s_wvalid && a_s_wready))) begin
                a_s_bvalid <= 1'b1;
                a_aw_seen  <= 1'b0;
                a_w_seen   <= 1'b0;
            end
            if (a_s_bvalid && a_s_bready) a_s_bvalid <= 1'b0;
        end
    end

    // ---------------- DUT B: 2 masters, fixed priority ----------------
    logic [BN*32-1:0] b_m_araddr, b_m_rdata, b_m_awaddr, b_m_wdata;
    logic [BN-1:0]    b_m_arvalid, b_m_arready, b_m_rvalid, b_m_rready;
    logic [BN-1:0]    b_m_awvalid, b_m_awready, b_m_wvalid, b_m_wready;
    logic [BN-1:0]    b_m_bvalid, b_m_bready;
    logic [BN*2-1:0]  b_m_rresp, b_m_bresp;
    logic [BN*4-1:0]  b_m_wstrb;
    logic [31:0]      b_s_araddr, b_s_rdata, b_s_awaddr, b_s_wdata;
    logic [3:0]       b_s_wstrb;
    logic [1:0]       b_s_rresp, b_s_bresp;
    logic             b_s_arvalid, b_s_arready, b_s_rvalid, b_s_rready;
    logic             b_s_awvalid, b_s_awready, b_s_wvalid, b_s_wready;
    logic             b_s_bvalid, b_s_bready;
    logic             b_busy;
    logic [0:0]       b_grant;

    axil_rr_arbiter #(.NUM_M(BN), .ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .m_araddr(b_m_araddr), .m_arvalid(b_m_arvalid), .m_arready(b_m_arready),
        .m_rdata(b_m_rdata), .m_rresp(b_m_rresp), .m_rvalid(b_m_rvalid), .m_rready(b_m_rready),
        .m_awaddr(b_m_awaddr), .m_awvalid(b_m_awvalid), .m_awready(b_m_awready),
        .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb), .m_wvalid(b_m_wvalid), .m_wready(b_m_wready),
        .m_bresp(b_m_bresp), .m_bvalid(b_m_bvalid), .m_bready(b_m_bready),
        .s_araddr(b_s_araddr), .s_arvalid(b_s_arvalid), .s_arready(b_s_arready),
        .s_rdata(b_s_rdata), .s_rresp(b_s_rresp), .s_rvalid(b_s_rvalid), .s_rready(b_s_rready),
        .s_awaddr(b_s_awaddr), .s_awvalid(b_s_awvalid), .s_awready(b_s_awready),
        .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_wvalid(b_s_wvalid), .s_wready(b_s_wready),
        .s_bresp(b_s_bresp), .s_bvalid(b_s_bvalid), .s_bready(b_s_bready),
        .busy(b_busy), .grant_id(b_grant)
    );

    // Slave B echoes the read address as data, one cycle after AR, with SLVERR.
    assign b_s_arready = 1'b1;
    assign b_s_rresp   = RESP_SLVERR;
    assign b_s_awready = 1'b0;
    assign b_s_wready  = 1'b0;
    assign b_s_bresp   = RESP_OKAY;
    assign b_s_bvalid  = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            b_s_rvalid <= 1'b0;
        end else if (b_s_arvalid && b_s_arready) begin
            b_s_rvalid <= 1'b1;
            b_s_rdata  <= b_s_araddr;
        end else if (b_s_rvalid && b_s_rready) begin
            b_s_rvalid <= 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_srvalid_a(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            neg();
            if (a_s_rvalid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk(tag, seen, 1'b1);
    endtask

    task automatic wait_idle_a(input string tag);
        for (int n = 0; n < 50; n++) begin
            neg();
            if (!a_busy) break;
            step();
        end
        chk(tag, a_busy, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int         rr_log [9];
    int         rr_cnt [AN];
    int         n_log;
    int         g;

    initial begin
        rst = 1'b1;
        a_m_araddr = '0; a_m_arvalid = '0; a_m_rready = '1;
        a_m_awaddr = '0; a_m_awvalid = '0; a_m_wdata = '0; a_m_wstrb = '0;
        a_m_wvalid = '0; a_m_bready = '1;
        a_rd_lat = 4'd2; a_rd_data = 32'hDEAD_BEEF;
        b_m_araddr = '0; b_m_arvalid = '0; b_m_rready = '1;
        b_m_awaddr = '0; b_m_awvalid = '0; b_m_wdata = '0; b_m_wstrb = '0;
        b_m_wvalid = '0; b_m_bready = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        neg();
        chk("rst_a_ctl", a_ctl, 20'h0);
        chk("rst_a_busy_grant", {a_busy, a_grant}, {1'b0, 2'd0});
        chk("rst_b_busy_ctl", {b_busy, b_grant, b_m_arready, b_m_rvalid, b_s_arvalid},
            {1'b0, 1'b0, 2'b00, 2'b00, 1'b0});

        // Fixed priority on B: both masters request together
        step();
        b_m_arvalid = 2'b11;
        b_m_araddr  = {32'h0000_0200, 32'h0000_0100};
        neg();
        chk("fp_idle_bubble", {b_busy, b_s_arvalid}, 2'b00);
        step();
        neg();
        chk("fp_first_grant", {b_grant, b_s_arvalid, b_m_arready}, {1'b0, 1'b1, 2'b01});
        chk("fp_first_addr", b_s_araddr, 32'h0000_0100);
        step();
        b_m_arvalid[0] = 1'b0;
        neg();
        chk("fp_rvalid0", b_m_rvalid, 2'b01);
        chk("fp_rdata0", b_m_rdata[31:0], 32'h0000_0100);
        chk("fp_rresp0", b_m_rresp[1:0], RESP_SLVERR);
        step();
        neg();
        chk("fp_bubble", {b_busy, b_s_arvalid}, 2'b00);
        step();
        neg();
        chk("fp_second_grant", {b_grant, b_s_arvalid, b_m_arready}, {1'b1, 1'b1, 2'b10});
        chk("fp_second_addr", b_s_araddr, 32'h0000_0200);
        step();
        b_m_arvalid[1] = 1'b0;
        neg();
        chk("fp_rvalid1", {b_m_rvalid, b_m_rdata[63:32]}, {2'b10, 32'h0000_0200});
        step();
        neg();
        chk("fp_done", b_busy, 1'b0);

        // Single read on A from master 1, slave answers after 3 cycles
        step();
        a_m_arvalid[1] = 1'b1;
        a_m_araddr[63:32] = 32'h8000_0004;
        neg();
        chk("rd_idle_bubble", {a_busy, a_s_arvalid}, 2'b00);
        step();
        neg();
        chk("rd_grant", {a_busy, a_grant, a_s_arvalid, a_m_arready}, {1'b1, 2'd1, 1'b1, 3'b010});
        chk("rd_addr", a_s_araddr, 32'h8000_0004);
        step();
        a_m_arvalid[1] = 1'b0;
        wait_srvalid_a("rd_wait_rvalid");
        chk("rd_rvalid", {a_m_rvalid, a_s_rready}, {3'b010, 1'b1});
        chk("rd_rdata1", a_m_rdata[63:32], 32'hDEAD_BEEF);
        chk("rd_rresp1", a_m_rresp[3:2], RESP_OKAY);
        step();
        neg();
        chk("rd_done", {a_busy, a_m_rvalid}, {1'b0, 3'b000});

        // Write from master 2 with W two cycles ahead of AW
        step();
        a_m_wvalid[2] = 1'b1;
        a_m_wdata[95:64] = 32'h1234_5678;
        a_m_wstrb[11:8]  = 4'b0011;
        a_m_awaddr[95:64] = 32'h0000_1000;
        neg();
        chk("wr_idle_bubble", {a_busy, a_s_wvalid}, 2'b00);
        step();
        neg();
        chk("wr_grant", {a_busy, a_grant, a_s_wvalid, a_s_awvalid, a_m_wready},
            {1'b1, 2'd2, 1'b1, 1'b0, 3'b100});
        step();
        a_m_awvalid[2] = 1'b1;
        neg();
        chk("wr_w_fenced", {a_s_wvalid, a_m_wready, a_s_awvalid, a_m_awready},
            {1'b0, 3'b000, 1'b1, 3'b100});
        step();
        a_m_awvalid[2] = 1'b0;
        a_m_wvalid[2]  = 1'b0;
        neg();
        chk("wr_b_owner", {a_m_bvalid, a_s_bready, a_busy}, {3'b100, 1'b1, 1'b1});
        chk("wr_bresp", a_m_bresp[5:4], RESP_OKAY);
        chk("wr_hs_counts", {a_aw_cnt, a_w_cnt}, {8'd1, 8'd1});
        chk("wr_payload", {a_cap_awaddr, a_cap_wdata}, {32'h0000_1000, 32'h1234_5678});
        chk("wr_strb", a_cap_wstrb, 4'b0011);
        step();
        neg();
        chk("wr_done", {a_busy, a_m_bvalid}, {1'b0, 3'b000});

        // Backpressure: master 0 stalls rready while master 1 waits
        step();
        a_rd_lat = 4'd0;
        a_m_rready = 3'b110;
        a_m_araddr[31:0]  = 32'h0000_0010;
        a_m_araddr[63:32] = 32'h0000_0020;
        a_m_arvalid = 3'b011;
        neg();
        chk("bp_idle_bubble", a_busy, 1'b0);
        step();
        neg();
        chk("bp_grant0", {a_grant, a_s_arvalid, a_m_arready}, {2'd0, 1'b1, 3'b001});
        step();
        a_m_arvalid[0] = 1'b0;
        wait_srvalid_a("bp_wait_rvalid");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                step();
                neg();
            end
            chk("bp_stall", {a_s_rready, a_busy, a_grant, a_m_arready, a_m_rvalid},
                {1'b0, 1'b1, 2'd0, 3'b000, 3'b001});
        end
        step();
        a_m_rready[0] = 1'b1;
        neg();
        chk("bp_release", {a_s_rready, a_m_rvalid}, {1'b1, 3'b001});
        step();
        neg();
        chk("bp_bubble", {a_busy, a_s_arvalid}, 2'b00);
        step();
        neg();
        chk("bp_next_grant", {a_busy, a_grant, a_s_arvalid, a_m_arready},
            {1'b1, 2'd1, 1'b1, 3'b010});
        step();
        a_m_arvalid[1] = 1'b0;
        wait_idle_a("bp_done");

        // Reset in the middle of a write after the AW handshake
        step();
        a_m_awvalid[0] = 1'b1;
        a_m_awaddr[31:0] = 32'h0000_0040;
        neg();
        chk("mr_idle_bubble", a_busy, 1'b0);
        step();
        neg();
        chk("mr_aw", {a_busy, a_grant, a_s_awvalid, a_s_wvalid}, {1'b1, 2'd0, 1'b1, 1'b0});
        step();
        rst = 1'b1;
        neg();
        chk("mr_aw_fenced", {a_busy, a_s_awvalid, a_m_awready}, {1'b1, 1'b0, 3'b000});
        step();
        rst = 1'b0;
        a_m_awvalid[0] = 1'b0;
        neg();
        chk("mr_busy", {a_busy, a_grant}, {1'b0, 2'd0});
        chk("mr_ctl", a_ctl, 20'h0);

        // Round-robin fairness: all three masters read continuously
        step();
        a_m_rready = 3'b111;
        a_m_araddr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        a_m_arvalid = 3'b111;
        for (int k = 0; k < 9; k++) rr_log[k] = 7;
        for (int k = 0; k < AN; k++) rr_cnt[k] = 0;
        n_log = 0;
        for (int n = 0; n < 200 && n_log < 9; n++) begin
            neg();
            if (a_s_arvalid && a_s_arready) begin
                g = int'(a_grant);
                rr_log[n_log] = g;
                n_log++;
                if (g < AN) rr_cnt[g]++;
                step();
                if (g < AN && rr_cnt[g] >= 3) a_m_arvalid[g] = 1'b0;
            end else begin
                step();
            end
        end
        for (int k = 0; k < 9; k++) chk($sformatf("rr_order_%0d", k), rr_log[k], k % 3);
        a_m_arvalid = '0;
        wait_idle_a("rr_done");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axil_rr_arbiter.md
Name: axil_rr_arbiter

Overview:
N-master to 1-slave AXI4-Lite arbiter with full read and write support. It sits between the core's bus masters (IFU, LSU, later DMA/debug) and the single shared memory/peripheral slave port. Exactly one transaction, read or write, owns the slave at a time. Grant policy is selectable: fixed priority or round-robin.

Parameters:
NUM_M, 2, number of masters (2..8); master 0 is highest fixed priority
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
RR_EN, 1, 1 = round-robin grant, 0 = fixed priority (lowest index wins)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m_araddr  in  NUM_M*ADDR_W  master read addresses, master i in slice i
m_arvalid / m_arready  in / out  NUM_M  read address handshake
m_rdata  out  NUM_M*DATA_W  read data; all slices driven with the slave rdata
m_rresp  out  NUM_M*2  read response; all slices driven with the slave rresp
m_rvalid / m_rready  out / in  NUM_M  read data handshake
m_awaddr  in  NUM_M*ADDR_W  write addresses
m_awvalid / m_awready  in / out  NUM_M  write address handshake
m_wdata  in  NUM_M*DATA_W  write data
m_wstrb  in  NUM_M*DATA_W/8  write strobes
m_wvalid / m_wready  in / out  NUM_M  write data handshake
m_bresp  out  NUM_M*2  write response; all slices driven with the slave bresp
m_bvalid / m_bready  out / in  NUM_M  write response handshake
s_araddr, s_arvalid, s_arready, s_rdata, s_rresp, s_rvalid, s_rready  slave-side read channels (directions mirrored)
s_awaddr, s_awvalid, s_awready, s_wdata, s_wstrb, s_wvalid, s_wready, s_bresp, s_bvalid, s_bready  slave-side write channels (directions mirrored)
busy  out  1  high whenever state != IDLE
grant_id  out  $clog2(NUM_M)  index of the current owner; valid while busy

Behaviour:
- FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B. Registered: state, grant_id, is_write, aw_done, w_done, rr_ptr.
- Reset: state=IDLE, rr_ptr=0, grant_id=0, aw_done=w_done=0. All m_* ready/valid and s_* valid/ready outputs are 0.
- req[i] = m_arvalid[i] | m_awvalid[i] | m_wvalid[i].
- IDLE: no slave valids asserted. If req != 0, pick winner W:
  - Fixed priority: lowest index.
  - Round-robin: first set bit searching from rr_ptr upward with wrap.
  - Register grant_id=W. Next state is RD_A if m_arvalid[W], else WR_AW. A master requesting both read and write is served read first.
- Arbitration latency: 1 cycle from request to the slave-side valid.
- Channel forwarding, all combinational, only from master grant_id:
  - Every other master sees ready=0 and valid=0.
  - Address, data and strobe buses are muxed by grant_id.
- RD_A: s_arvalid = m_arvalid[g], and m_arready[g] = s_arready. On handshake → RD_D.
- RD_D: s_rready = m_rready[g], and m_rvalid[g] = s_rvalid. On handshake → IDLE.
- WR_AW: AW and W are forwarded independently.
  - aw_done sets on the AW handshake; w_done sets on the W handshake.
  - Once a channel is done, its valid to the slave and its ready to the master are forced to 0.
  - Same-cycle handshakes of both channels are legal. Transition to WR_B when both are done, counting same-cycle completion.
- WR_B: s_bready = m_bready[g], and m_bvalid[g] = s_bvalid. On handshake → IDLE and clear aw_done/w_done.
- On every return to IDLE, when RR_EN=1: rr_ptr = (grant_id+1) mod NUM_M.
- No back-to-back grant in the completion cycle. IDLE always lasts at least 1 cycle, which gives a bubble between transactions.
- A master must hold valid and payload stable until its handshake, per AXI. A master that drops valid before grant simply loses arbitration; no error is raised.
- rst asserted mid-transaction: the FSM returns to IDLE the next cycle and the in-flight transaction is abandoned. The slave shares rst, so no orphan response can reach a master.
- NUM_M=1: the arbiter degenerates to a pass-through that keeps the IDLE bubble.

Decomposition:
- Shared package axil_pkg holds:
  - the FSM state enum (arb_state_t);
  - AXI resp constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10);
  - a localparam function for the grant-index width.
- One sub-module: rr_picker (req vector, ptr, RR_EN → winner index, any). It is combinational and unit-testable in isolation.

Test Plan:
- Single read: master 1 issues araddr=0x8000_0004; slave answers rdata=0xDEAD_BEEF after 3 cycles → m_rdata slice 1 = 0xDEAD_BEEF with m_rvalid[1] for exactly the handshake cycle; master 0 sees no valid or ready.
- Fixed priority (RR_EN=0): masters 0 and 1 both assert arvalid in the same cycle → master 0 is served first; master 1 is granted in the IDLE cycle after master 0's rvalid&rready.
- Round-robin fairness (RR_EN=1, NUM_M=3): all three masters request continuously for 9 transactions → grant order 0,1,2,0,1,2,0,1,2.
- Write with W before AW: wvalid asserted 2 cycles before awvalid, data 0x1234_5678, wstrb 4'b0011 → slave sees one W handshake and one AW handshake; state reaches WR_B; bresp=OKAY is returned only to the owner.
- Backpressure: master holds rready=0 for 5 cycles after s_rvalid → s_rready stays 0, busy stays 1, and no other master is granted during the stall.
- Reset mid-write: rst pulsed in WR_AW with aw_done=1 → the next cycle shows busy=0, all valid/ready outputs 0 and rr_ptr=0; a new read then completes normally.
